updown_sequencer: RTL and testbench

- Drives the Up/Down command inputs of the 0..8 ring up/down counter FSM, stepping it to a requested target value.
- Takes the target from the controlling logic, watches the counter's state bus as feedback, and issues one Up or Down pulse per confirmed step.
- Always moves in the shortest direction around the 9-state ring.
- Recovers the counter from error state 15 before stepping.

---
 rtl/updown_sequencer.sv | 139 +++++++++++++
 tb/tb_updown_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/updown_sequencer.sv
// rtl/updown_sequencer.sv - steps a 0..8 ring up/down counter to a target via Up/Down pulses
module updown_sequencer #(
    parameter int WAIT_MAX = 4,
    parameter int RING_N   = 9
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic [3:0] Target,
    input  logic [3:0] CounterState,
    output logic       Up,
    output logic       Down,
    output logic       Busy,
    output logic       Done,
    output logic       Err,
    output logic [3:0] StepCount
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_RECOVER = 3'd2;
    localparam logic [2:0] S_STEP    = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERR     = 3'd6;

    localparam logic [3:0] RING_TOP = 4'(RING_N - 1);
    localparam logic [4:0] RING_N5  = 5'(RING_N);
    localparam logic [4:0] HALF     = 5'((RING_N - 1) / 2);
    localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);
    localparam logic [3:0] ERR_ST   = 4'hF;

    logic [2:0] state_q, state_d;
    logic [3:0] tgt_q, tgt_d;
    logic [3:0] prev_q, prev_d;
    logic [3:0] wait_q, wait_d;
    logic [3:0] steps_q, steps_d;
    logic       dir_q, dir_d;
    logic       err_q, err_d;
    logic       up_q, down_q, busy_q, done_q;
    logic [4:0] diff, dist_up;

    // Forward distance around the ring; a negative difference wraps by adding RING_N.
    assign diff    = {1'b0, tgt_q} - {1'b0, CounterState};
    assign dist_up = diff[4] ? (diff + RING_N5) : diff;

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        prev_d  = prev_q;
        wait_d  = wait_q;
        steps_d = steps_q;
        dir_d   = dir_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    tgt_d   = Target;
                    err_d   = 1'b0;
                    steps_d = 4'd0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                wait_d = 4'd0;
                if (tgt_q > RING_TOP)                state_d = S_ERR;
                else if (CounterState == ERR_ST)     state_d = S_RECOVER;
                else if (CounterState > RING_TOP)    state_d = S_ERR;
                else if (CounterState == tgt_q)      state_d = S_DONE;
                else begin
                    dir_d   = (dist_up <= HALF);
                    state_d = S_STEP;
                end
            end
            S_RECOVER: begin
                prev_d  = ERR_ST;
                wait_d  = 4'd0;
                state_d = S_WAIT;
            end
            S_STEP: begin
                prev_d  = CounterState;
                steps_d = (steps_q == 4'hF) ? steps_q : steps_q + 4'd1;
                wait_d  = 4'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (CounterState != prev_q) begin
                    wait_d  = 4'd0;
                    state_d = S_CHECK;
                end else begin
                    wait_d = wait_q + 4'd1;
                    if (wait_d == WAIT_LIM) state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_ERR) err_d = 1'b1;
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            tgt_q   <= 4'd0;
            prev_q  <= 4'd0;
            wait_q  <= 4'd0;
            steps_q <= 4'd0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            prev_q  <= prev_d;
            wait_q  <= wait_d;
            steps_q <= steps_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            up_q    <= (state_d == S_RECOVER) || ((state_d == S_STEP) && dir_d);
            down_q  <= (state_d == S_STEP) && !dir_d;
            busy_q  <= (state_d == S_CHECK) || (state_d == S_RECOVER) ||
                       (state_d == S_STEP)  || (state_d == S_WAIT);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign Up        = up_q;
    assign Down      = down_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Err       = err_q;
    assign StepCount = steps_q;

endmodule

// File: tb/tb_updown_sequencer.sv
// tb/tb_updown_sequencer.sv - scoreboard bench for updown_sequencer with a ring counter model
module tb_updown_sequencer;

    logic       clock = 1'b0;
    logic       Reset;
    logic       Start;
    logic [3:0] Target;
    logic [3:0] CounterState;
    logic       Up, Down, Busy, Done, Err;
    logic [3:0] StepCount;

    updown_sequencer #(.WAIT_MAX(4), .RING_N(9)) dut (
        .clock(clock), .Reset(Reset), .Start(Start), .Target(Target),
        .CounterState(CounterState), .Up(Up), .Down(Down), .Busy(Busy),
        .Done(Done), .Err(Err), .StepCount(StepCount)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       err;
        logic [3:0] steps;
        int         ups;
        int         downs;
        logic [3:0] final_cnt;
    } exp_t;
    exp_t sb[$];

    // Counter model: one-cycle response to Up/Down, 15 recovers to 0 on Up.
    logic       freeze = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] cnt;
    always @(posedge clock) begin
        if (load) cnt <= load_val;
        else if (!freeze) begin
            if (Up)        cnt <= (cnt == 4'd8 || cnt == 4'd15) ? 4'd0 : cnt + 4'd1;
            else if (Down) cnt <= (cnt == 4'd0) ? 4'd8 : cnt - 4'd1;
        end
    end
    assign CounterState = cnt;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    int   ups = 0;
    int   downs = 0;
    logic err_prev = 1'b0;
    always @(negedge clock) begin : monitor
        exp_t e;
        if (Reset) begin
            ups = 0;
            downs = 0;
            err_prev = 1'b0;
        end else begin
            if (Up && Down) check("up_down_exclusive", 1, 0);
            ups += int'(Up);
            downs += int'(Down);
            if (Done || (Err && !err_prev)) begin
                if (sb.size() == 0) check("unexpected_completion", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("err", int'(Err), int'(e.err));
                    check("done", int'(Done), int'(!e.err));
                    check("step_count", int'(StepCount), int'(e.steps));
                    check("up_pulses", ups, e.ups);
                    check("down_pulses", downs, e.downs);
                    check("busy_low", int'(Busy), 0);
                    if (!e.err) check("final_counter", int'(cnt), int'(e.final_cnt));
                end
                ups = 0;
                downs = 0;
            end
            err_prev = Err;
        end
    end

    task automatic load_cnt(input logic [3:0] v);
        @(negedge clock);
        load = 1'b1;
        load_val = v;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic run(input logic [3:0] tgt, input logic hold, input exp_t e);
        bit finished = 0;
        sb.push_back(e);
        @(negedge clock);
        Start = 1'b1;
        Target = tgt;
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            Start = hold;
            if (hold) Target = 4'd6;
            if (!Busy) begin
                finished = 1;
                break;
            end
        end
        Start = 1'b0;
        if (!finished) check("busy_timeout", 1, 0);
        @(negedge clock);
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Target = 4'd0;
        load_cnt(4'd0);
        @(negedge clock);
        check("rst_up", int'(Up), 0);
        check("rst_down", int'(Down), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_done", int'(Done), 0);
        check("rst_err", int'(Err), 0);
        check("rst_steps", int'(StepCount), 0);
        Reset = 1'b0;

        run(4'd3, 1'b0, '{1'b0, 4'd3, 3, 0, 4'd3});        // 0 -> 3 up
        load_cnt(4'd1);
        run(4'd7, 1'b0, '{1'b0, 4'd3, 0, 3, 4'd7});        // 1 -> 0 -> 8 -> 7 down
        load_cnt(4'd15);
        run(4'd2, 1'b0, '{1'b0, 4'd2, 3, 0, 4'd2});        // recover then 2 up
        load_cnt(4'd7);
        run(4'd0, 1'b0, '{1'b0, 4'd2, 2, 0, 4'd0});        // 7 -> 8 -> 0 wrap
        load_cnt(4'd0);
        run(4'd8, 1'b0, '{1'b0, 4'd1, 0, 1, 4'd8});        // 0 -> 8 down wrap
        load_cnt(4'd5);
        run(4'd5, 1'b0, '{1'b0, 4'd0, 0, 0, 4'd5});        // already there

        // Out-of-range target: Err two cycles after Start, no pulses
        sb.push_back('{1'b1, 4'd0, 0, 0, 4'd0});
        @(negedge clock);
        Start = 1'b1;
        Target = 4'd11;
        @(negedge clock);
        Start = 1'b0;
        @(negedge clock);
        check("err_two_cycles", int'(Err), 1);
        check("err_no_done", int'(Done), 0);
        repeat (3) @(negedge clock);
        check("err_sticky", int'(Err), 1);
        run(4'd7, 1'b0, '{1'b0, 4'd2, 2, 0, 4'd7});        // 5 -> 7, clears Err

        // Frozen counter: one pulse, then timeout
        load_cnt(4'd0);
        freeze = 1'b1;
        run(4'd3, 1'b0, '{1'b1, 4'd1, 1, 0, 4'd0});
        freeze = 1'b0;

        // Start held during Busy with another Target must not retarget
        load_cnt(4'd0);
        run(4'd2, 1'b1, '{1'b0, 4'd2, 2, 0, 4'd2});

        // Reset mid-WAIT with Start held
        load_cnt(4'd0);
        @(negedge clock);
        Start = 1'b1;
        Target = 4'd4;
        @(negedge clock);
        Start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        Start = 1'b1;
        check("mid_busy", int'(Busy), 1);
        Reset = 1'b1;
        @(negedge clock);
        check("mrst_up", int'(Up), 0);
        check("mrst_down", int'(Down), 0);
        check("mrst_busy", int'(Busy), 0);
        check("mrst_done", int'(Done), 0);
        check("mrst_err", int'(Err), 0);
        check("mrst_steps", int'(StepCount), 0);
        Reset = 1'b0;
        Start = 1'b0;
        repeat (4) @(negedge clock);
        check("idle_after_reset", int'(Busy), 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
